adder_ahead_pipe: RTL



---
 rtl/adder_ahead_pkg.sv | 24 ++
 rtl/adder_ahead_cla4.sv | 39 +++
 rtl/adder_ahead_pipe.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/adder_ahead_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
// Holds the lookahead group width, the group-count helper and the
// per-group slice of the stage-1 pipeline payload.
package adder_ahead_pkg;

  // Width of one lookahead carry unit.
  localparam int GROUP_W = 4;

  // Number of 4-bit lookahead groups covering an operand of the given width.
  function automatic int group_count(input int width);
    return width / GROUP_W;
  endfunction

  // One group's worth of stage-1 state: bitwise xor/propagate/generate
  // terms plus the group generate/propagate produced by its carry unit.
  typedef struct packed {
    logic [GROUP_W-1:0] x;
    logic [GROUP_W-1:0] p;
    logic [GROUP_W-1:0] g;
    logic               gg;
    logic               pg;
  } grp_payload_t;

endpackage

// File: rtl/adder_ahead_cla4.sv
// Combinational 4-bit lookahead carry unit.
// From bit generate/propagate terms and a carry-in it produces the carries
// out of each bit position (c[4:1]) and the group generate/propagate.
// Propagate may be OR-form (a|b); every equation holds for either form.
module adder_ahead_cla4
  import adder_ahead_pkg::*;
(
  input  logic [GROUP_W-1:0] g,
  input  logic [GROUP_W-1:0] p,
  input  logic               c_in,
  output logic [GROUP_W:1]   c,
  output logic               grp_g,
  output logic               grp_p
);

  // Group terms are a pure sum-of-products over the four bits.
  assign grp_g = g[3]
               | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);

  assign grp_p = &p;

  // Each bit carry is expanded in full so no carry depends on another one.
  assign c[1] = g[0]
              | (p[0] & c_in);

  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & c_in);

  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_in);

  assign c[4] = grp_g | (grp_p & c_in);

endmodule

// File: rtl/adder_ahead_pipe.sv
// Two-stage pipelined carry-lookahead adder with valid/ready on both sides.
// Stage 1 registers bitwise x/p/g terms, per-group G/P and the carry-in.
// Stage 2 resolves group carries by lookahead, expands them into bit carries
// with one lookahead unit per group, and registers sum and carry-out.
// Optional feature macro: ADDER_AHEAD_OVF_EN adds the signed-overflow
// output ovf_o, computed from operand MSBs carried through stage 1.
// WIDTH must be a multiple of 4 and at least 4.
module adder_ahead_pipe
  import adder_ahead_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
`ifdef ADDER_AHEAD_OVF_EN
  output logic             ovf_o,
`endif
  output logic             cout_o
);

  localparam int NG = group_count(WIDTH);

  // Full stage-1 payload: every group slice plus carry-in (and MSBs for ovf).
  typedef struct packed {
    grp_payload_t [NG-1:0] grp;
    logic                  cin;
`ifdef ADDER_AHEAD_OVF_EN
    logic                  a_msb;
    logic                  b_msb;
`endif
  } s1_payload_t;

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  logic v1;
  logic v2;
  logic ld1;
  logic ld2;

  // Stage 2 can take new data when empty or when its result leaves now;
  // stage 1 can take new data when empty or when it drains into stage 2.
  assign ld2     = !v2 || ready_i;
  assign ld1     = !v1 || ld2;
  assign ready_o = ld1;
  assign valid_o = v2;

  // ---------------------------------------------------------------------
  // Stage 1: per-bit terms and group generate/propagate
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0]     g_bit;
  logic [WIDTH-1:0]     p_bit;
  logic [WIDTH-1:0]     x_bit;
  logic [NG-1:0]        s1_gg;
  logic [NG-1:0]        s1_pg;
  logic [GROUP_W*NG-1:0] unused_s1_c;

  assign g_bit = a_i & b_i;
  assign p_bit = a_i | b_i;
  assign x_bit = a_i ^ b_i;

  // Only G/P are needed from these units; their bit carries are discarded.
  for (genvar k = 0; k < NG; k++) begin : g_s1_cla
    adder_ahead_cla4 u_cla (
      .g     (g_bit[GROUP_W*k +: GROUP_W]),
      .p     (p_bit[GROUP_W*k +: GROUP_W]),
      .c_in  (1'b0),
      .c     (unused_s1_c[GROUP_W*k +: GROUP_W]),
      .grp_g (s1_gg[k]),
      .grp_p (s1_pg[k])
    );
  end

  s1_payload_t s1_next;
  s1_payload_t s1_q;

  // Pack the stage-1 terms into one payload word.
  // NOTE: every variable assigned in always_comb gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    s1_next = '0;
    for (int k = 0; k < NG; k++) begin
      s1_next.grp[k].x  = x_bit[GROUP_W*k +: GROUP_W];
      s1_next.grp[k].p  = p_bit[GROUP_W*k +: GROUP_W];
      s1_next.grp[k].g  = g_bit[GROUP_W*k +: GROUP_W];
      s1_next.grp[k].gg = s1_gg[k];
      s1_next.grp[k].pg = s1_pg[k];
    end
    s1_next.cin = cin_i;
`ifdef ADDER_AHEAD_OVF_EN
    s1_next.a_msb = a_i[WIDTH-1];
    s1_next.b_msb = b_i[WIDTH-1];
`endif
  end

  // Stage-1 register: advances only on load, captures data only with valid.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1   <= 1'b0;
      s1_q <= '0;
    end else if (ld1) begin
      v1 <= valid_i;
      if (valid_i) begin
        s1_q <= s1_next;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: group carry lookahead, bit carries, sum
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_g;
  logic [NG-1:0]    r_gg;
  logic [NG-1:0]    r_pg;

  // Unpack the registered payload into flat bit and group vectors.
  always_comb begin
    r_x  = '0;
    r_p  = '0;
    r_g  = '0;
    r_gg = '0;
    r_pg = '0;
    for (int k = 0; k < NG; k++) begin
      r_x[GROUP_W*k +: GROUP_W] = s1_q.grp[k].x;
      r_p[GROUP_W*k +: GROUP_W] = s1_q.grp[k].p;
      r_g[GROUP_W*k +: GROUP_W] = s1_q.grp[k].g;
      r_gg[k]                   = s1_q.grp[k].gg;
      r_pg[k]                   = s1_q.grp[k].pg;
    end
  end

  logic [NG:0] c_grp;

  // Second lookahead level: each group carry-in is an independent
  // sum-of-products of group G/P and cin, so no carry waits on another.
  // With a single group this reduces to c[1] = G | P&cin.
  always_comb begin : group_lookahead
    logic acc;
    logic term;
    c_grp    = '0;
    acc      = 1'b0;
    term     = 1'b0;
    c_grp[0] = s1_q.cin;
    for (int k = 0; k < NG; k++) begin
      acc = s1_q.cin;
      for (int m = 0; m <= k; m++) begin
        acc = acc & r_pg[m];
      end
      for (int j = 0; j <= k; j++) begin
        term = r_gg[j];
        for (int m = j + 1; m <= k; m++) begin
          term = term & r_pg[m];
        end
        acc = acc | term;
      end
      c_grp[k+1] = acc;
    end
  end

  logic [WIDTH-1:0]            carry_in_bit;
  logic [(GROUP_W-1)*NG-1:0]   s2_c;
  logic [NG-1:0]               unused_s2_c4;
  logic [NG-1:0]               unused_s2_gg;
  logic [NG-1:0]               unused_s2_pg;

  // Per-group lookahead expands each group carry-in into bit carries.
  // The group's own carry-out is already known from the level above.
  for (genvar k = 0; k < NG; k++) begin : g_s2_cla
    adder_ahead_cla4 u_cla (
      .g     (r_g[GROUP_W*k +: GROUP_W]),
      .p     (r_p[GROUP_W*k +: GROUP_W]),
      .c_in  (c_grp[k]),
      .c     ({unused_s2_c4[k], s2_c[(GROUP_W-1)*k +: (GROUP_W-1)]}),
      .grp_g (unused_s2_gg[k]),
      .grp_p (unused_s2_pg[k])
    );

    assign carry_in_bit[GROUP_W*k]                   = c_grp[k];
    assign carry_in_bit[GROUP_W*k+1 +: (GROUP_W-1)] = s2_c[(GROUP_W-1)*k +: (GROUP_W-1)];
  end

  logic [WIDTH-1:0] sum_next;
  assign sum_next = r_x ^ carry_in_bit;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

`ifdef ADDER_AHEAD_OVF_EN
  logic ovf_q;

  // Overflow register shares stage 2's load and hold behaviour.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else if (ld2 && v1) begin
      ovf_q <= (s1_q.a_msb == s1_q.b_msb) && (sum_next[WIDTH-1] != s1_q.a_msb);
    end
  end

  assign ovf_o = ovf_q;
`endif

  // Stage-2 register: holds its result while the consumer stalls.
  // NOTE: result registers are reset (not left to power-up) because their value is visible on the ports right after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v2     <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (ld2) begin
      v2 <= v1;
      if (v1) begin
        sum_q  <= sum_next;
        cout_q <= c_grp[NG];
      end
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule
